// File: rtl/uart_frame_tx_if.sv
// Byte stream link from the frame transmitter to the UART byte transmitter.
// Latency: none, wires only.
// Backpressure: to_uart_ready from the UART side stalls the byte presented by the master.
interface uart_frame_tx_if;
    logic [7:0] to_uart_data;
    logic       to_uart_valid;
    logic       to_uart_ready;
    logic       to_uart_error;

    modport master (
        output to_uart_data,
        output to_uart_valid,
        output to_uart_error,
        input  to_uart_ready
    );

    modport slave (
        input  to_uart_data,
        input  to_uart_valid,
        input  to_uart_error,
        output to_uart_ready
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Snapshots CHANNELS x DATA_BYTES samples and streams SOM, payload, optional checksum, EOM.
// Latency: SOM is presented the cycle after start is seen in IDLE; one byte per clk at full rate.
// Backpressure: the presented byte is held stable until to_uart_ready accepts it; valid never drops without a transfer.
module uart_frame_tx #(
    parameter int         DATA_BYTES  = 4,
    parameter int         CHANNELS    = 1,
    parameter int         CHECKSUM_EN = 1,
    parameter int         CONTINUOUS  = 0,
    parameter logic [7:0] SOM_BYTE    = 8'h73,
    parameter logic [7:0] EOM_BYTE    = 8'h65
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CHANNELS*DATA_BYTES*8-1:0] signal,
    uart_frame_tx_if.master                  tx,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             overrun
);
    localparam int NB = CHANNELS * DATA_BYTES;
    localparam int IW = $clog2(NB) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOM,
        S_PAY,
        S_CSUM,
        S_EOM
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic [NB-1:0][7:0]   snap_q, snap_d;

    logic [NB-1:0][7:0]   snap_in;
    logic [IW-1:0]        idx_nxt;
    logic [7:0]           nxt_byte;
    logic [7:0]           csum_sum;
    logic                 xfer;
    logic                 eom_xfer;
    logic                 launch;

    // Reorder the sample bus into transmit order: channel 0 first, MSB byte first within a channel.
    always_comb begin
        snap_in = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                snap_in[k*DATA_BYTES + b] = signal[(k*DATA_BYTES + DATA_BYTES - 1 - b)*8 +: 8];
            end
        end
    end

    // Select the payload byte that follows the one currently on the bus.
    always_comb begin
        idx_nxt  = idx_q + IW'(1);
        nxt_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx_nxt == IW'(i)) begin
                nxt_byte = snap_q[i];
            end
        end
    end

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        data_d   = data_q;
        vld_d    = vld_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        xfer     = vld_q && tx.to_uart_ready;
        csum_sum = csum_q + data_q;
        eom_xfer = (state_q == S_EOM) && xfer;
        // A new frame launches from IDLE, or straight out of EOM when free-running.
        launch   = ((state_q == S_IDLE) && (start || (CONTINUOUS != 0))) ||
                   (eom_xfer && (CONTINUOUS != 0));

        case (state_q)
            S_IDLE: begin
                vld_d = 1'b0;
            end
            S_SOM: begin
                if (xfer) begin
                    state_d = S_PAY;
                    idx_d   = '0;
                    data_d  = snap_q[0];
                end
            end
            S_PAY: begin
                if (xfer) begin
                    csum_d = csum_sum;
                    if (idx_q == IW'(NB - 1)) begin
                        if (CHECKSUM_EN != 0) begin
                            state_d = S_CSUM;
                            data_d  = csum_sum;
                        end else begin
                            state_d = S_EOM;
                            data_d  = EOM_BYTE;
                        end
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = nxt_byte;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_EOM;
                    data_d  = EOM_BYTE;
                end
            end
            S_EOM: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        if (launch) begin
            snap_d  = snap_in;
            csum_d  = '0;
            idx_d   = '0;
            state_d = S_SOM;
            data_d  = SOM_BYTE;
            vld_d   = 1'b1;
        end

        // busy dips for one cycle after every accepted EOM, even when the next SOM follows at once.
        busy_d = (state_d != S_IDLE) && !eom_xfer;
        // Any start seen outside IDLE is dropped and remembered until reset.
        ovr_d  = ovr_q || (start && (state_q != S_IDLE));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

    assign tx.to_uart_data  = data_q;
    assign tx.to_uart_valid = vld_q;
    assign tx.to_uart_error = 1'b0;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign overrun          = ovr_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: three instances cover checksum, no-checksum and continuous modes.
// Expected byte streams come from an independent frame model pushed at stimulus time.
// Monitors pop and compare on every accepted byte and check hold-stable behaviour under stalls.
module tb_uart_frame_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_c_n;
    logic        start_a, start_b, start_c;
    logic [31:0] sig_a, sig_b, sig_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        ovr_a, ovr_b, ovr_c;

    uart_frame_tx_if if_a ();
    uart_frame_tx_if if_b ();
    uart_frame_tx_if if_c ();

    uart_frame_tx #(.DATA_BYTES(2), .CHANNELS(2), .CHECKSUM_EN(1), .CONTINUOUS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .signal(sig_a), .tx(if_a.master),
        .busy(busy_a), .frame_done(done_a), .overrun(ovr_a));

    uart_frame_tx #(.DATA_BYTES(4), .CHANNELS(1), .CHECKSUM_EN(0), .CONTINUOUS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .signal(sig_b), .tx(if_b.master),
        .busy(busy_b), .frame_done(done_b), .overrun(ovr_b));

    uart_frame_tx #(.DATA_BYTES(2), .CHANNELS(2), .CHECKSUM_EN(1), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst_n(rst_c_n), .start(start_c), .signal(sig_c), .tx(if_c.master),
        .busy(busy_c), .frame_done(done_c), .overrun(ovr_c));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    int busy_cnt_a = 0, fd_cnt_a = 0, vld_cnt_a = 0;
    int busy_cnt_b = 0, fd_cnt_b = 0;
    int fd_cnt_c = 0, busy_low_c = 0, vld_low_c = 0;
    bit stall_a = 0, stall_b = 0, c_en = 0, c_started = 0;
    logic [7:0] held_a, held_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b);
        case (id)
            0:       qa.push_back(b);
            1:       qb.push_back(b);
            default: qc.push_back(b);
        endcase
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    // Frame model: SOM, per-channel bytes MSB first, optional mod-256 payload sum, EOM.
    task automatic exp_frame(input int id, input logic [63:0] sig, input int db, input int ch, input bit ce);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        push(id, 8'h73);
        for (int k = 0; k < ch; k++) begin
            for (int j = db - 1; j >= 0; j--) begin
                b   = sig[(k*db + j)*8 +: 8];
                sum = sum + b;
                push(id, b);
            end
        end
        if (ce) push(id, sum);
        push(id, 8'h65);
    endtask

    task automatic set_start(input int id, input logic v);
        if (id == 0) start_a = v; else start_b = v;
    endtask

    // One-cycle start pulse, then confirm SOM is presented right after the sampling edge.
    task automatic pulse(input int id);
        @(posedge clk); #1;
        set_start(id, 1'b1);
        @(posedge clk); #1;
        set_start(id, 1'b0);
        if (id == 0) begin
            chk("a_som_latency_vld", if_a.to_uart_valid, 1);
            chk("a_som_latency_dat", if_a.to_uart_data, 8'h73);
        end else begin
            chk("b_som_latency_vld", if_b.to_uart_valid, 1);
            chk("b_som_latency_dat", if_b.to_uart_data, 8'h73);
        end
    endtask

    // Wait for the scoreboard queue to empty, optionally randomising ready each cycle.
    task automatic drain(input int id, input int budget, input bit rnd);
        int n;
        n = 0;
        while (qsize(id) > 0 && n < budget) begin
            @(posedge clk); #1;
            if (rnd && id == 0) if_a.to_uart_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (qsize(id) > 0) chk("drain_timeout", 64'(qsize(id)), 0);
        if (id == 0) if_a.to_uart_ready = 1'b1;
    endtask

    // Monitor A: scoreboard compare on each accepted byte, hold check during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 0;
        end else begin
            if (stall_a) begin
                chk("a_hold_vld", if_a.to_uart_valid, 1);
                chk("a_hold_dat", if_a.to_uart_data, held_a);
            end
            if (if_a.to_uart_valid && if_a.to_uart_ready) begin
                if (qa.size() == 0) chk("a_extra_byte", if_a.to_uart_data, 64'h100);
                else chk("a_byte", if_a.to_uart_data, qa.pop_front());
            end
            stall_a = if_a.to_uart_valid && !if_a.to_uart_ready;
            held_a  = if_a.to_uart_data;
            if (busy_a) busy_cnt_a++;
            if (done_a) fd_cnt_a++;
            if (if_a.to_uart_valid) vld_cnt_a++;
        end
    end

    // Monitor B: same scoreboard discipline for the no-checksum instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_b = 0;
        end else begin
            if (stall_b) chk("b_hold_dat", if_b.to_uart_data, held_b);
            if (if_b.to_uart_valid && if_b.to_uart_ready) begin
                if (qb.size() == 0) chk("b_extra_byte", if_b.to_uart_data, 64'h100);
                else chk("b_byte", if_b.to_uart_data, qb.pop_front());
            end
            stall_b = if_b.to_uart_valid && !if_b.to_uart_ready;
            held_b  = if_b.to_uart_data;
            if (busy_b) busy_cnt_b++;
            if (done_b) fd_cnt_b++;
        end
    end

    // Monitor C: continuous stream; counts valid gaps and busy dips once streaming has begun.
    always @(negedge clk) begin
        if (rst_c_n && c_en) begin
            if (if_c.to_uart_valid) c_started = 1;
            if (c_started) begin
                if (!if_c.to_uart_valid) vld_low_c++;
                if (!busy_c) busy_low_c++;
                if (done_c) fd_cnt_c++;
            end
            if (if_c.to_uart_valid && if_c.to_uart_ready && qc.size() > 0)
                chk("c_byte", if_c.to_uart_data, qc.pop_front());
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; rst_c_n = 1'b0;
        start_a = 0; start_b = 0; start_c = 0;
        sig_a = 32'hBEEF_1234; sig_b = 32'hFFFF_FFFF; sig_c = 32'h0102_0304;
        if_a.to_uart_ready = 1'b0; if_b.to_uart_ready = 1'b0; if_c.to_uart_ready = 1'b0;

        #2;
        chk("rst_a_vld",  if_a.to_uart_valid, 0);
        chk("rst_a_dat",  if_a.to_uart_data, 0);
        chk("rst_a_err",  if_a.to_uart_error, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_done", done_a, 0);
        chk("rst_a_ovr",  ovr_a, 0);
        chk("rst_c_vld",  if_c.to_uart_valid, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_a_vld", if_a.to_uart_valid, 0);

        // Basic frame at full rate: 73 12 34 BE EF F3 65.
        if_a.to_uart_ready = 1'b1;
        busy_cnt_a = 0; fd_cnt_a = 0;
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        drain(0, 40, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_busy_cycles", busy_cnt_a, 7);
        chk("a_frame_done",  fd_cnt_a, 1);
        chk("a_ovr_clean",   ovr_a, 0);
        chk("a_err_zero",    if_a.to_uart_error, 0);

        // Random backpressure: same bytes, held stable while stalled.
        fd_cnt_a = 0;
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        drain(0, 200, 1);
        repeat (3) @(posedge clk);
        #1 chk("a_rnd_frame_done", fd_cnt_a, 1);

        // Sample bus changes right after the snapshot edge; frame must carry the old values.
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        sig_a = 32'h0;
        drain(0, 40, 0);
        sig_a = 32'hBEEF_1234;
        repeat (2) @(posedge clk);

        // Start during PAYLOAD: dropped, overrun sticks, frame unaffected.
        fd_cnt_a = 0;
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("a_ovr_set", ovr_a, 1);
        drain(0, 40, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_ovr_sticky",    ovr_a, 1);
        chk("a_ovr_no_extra",  if_a.to_uart_valid, 0);
        chk("a_ovr_frame_done", fd_cnt_a, 1);

        // No checksum, one 4-byte channel: 73 FF FF FF FF 65.
        if_b.to_uart_ready = 1'b1;
        busy_cnt_b = 0; fd_cnt_b = 0;
        exp_frame(1, 64'(sig_b), 4, 1, 0);
        pulse(1);
        drain(1, 40, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("b_busy_cycles", busy_cnt_b, 6);
        chk("b_frame_done",  fd_cnt_b, 1);

        // Continuous: four back-to-back frames, no valid gap, one busy dip and done pulse per frame.
        for (int f = 0; f < 4; f++) exp_frame(2, 64'(sig_c), 2, 2, 1);
        if_c.to_uart_ready = 1'b1;
        c_en = 1;
        @(posedge clk); #1;
        rst_c_n = 1'b1;
        n = 0;
        while (qc.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if_c.to_uart_ready = 1'b0;
        if (qc.size() > 0) chk("c_timeout", 64'(qc.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        c_en = 0;
        chk("c_frame_done", fd_cnt_c, 4);
        chk("c_busy_dips",  busy_low_c, 4);
        chk("c_vld_gaps",   vld_low_c, 0);
        chk("c_vld_next",   if_c.to_uart_valid, 1);
        chk("c_dat_next",   if_c.to_uart_data, 8'h73);

        // Reset mid-PAYLOAD: outputs clear at once; valid stays low until a new start.
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        n = 0;
        while (qa.size() > 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (qa.size() > 4) chk("a_rst_timeout", 64'(qa.size()), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",  if_a.to_uart_valid, 0);
        chk("mid_rst_dat",  if_a.to_uart_data, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_ovr",  ovr_a, 0);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        vld_cnt_a = 0;
        repeat (6) @(posedge clk);
        #1 chk("post_rst_idle", vld_cnt_a, 0);

        // Recovery frame after reset.
        fd_cnt_a = 0;
        exp_frame(0, 64'(sig_a), 2, 2, 1);
        pulse(0);
        drain(0, 40, 0);
        repeat (3) @(posedge clk);
        #1 chk("a_recover_done", fd_cnt_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised UART frame transmitter for the waveform generator's telemetry path; sits between sample sources and the UART byte transmitter.
- On a start request, snapshots CHANNELS samples of DATA_BYTES bytes each and emits one frame as a byte stream: SOM, payload, optional 8-bit checksum, EOM.
- Uses a true valid/ready byte handshake. Supports one-shot (triggered) mode and continuous mode.

Parameters:
- DATA_BYTES, 4, bytes per channel sample (1..8)
- CHANNELS, 1, number of channels per frame (1..8)
- CHECKSUM_EN, 1, 1 = insert checksum byte before EOM
- CONTINUOUS, 0, 1 = start next frame immediately after EOM; 0 = wait for start
- SOM_BYTE, 8'h73, start-of-message byte ('s')
- EOM_BYTE, 8'h65, end-of-message byte ('e')

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, frame request, sampled only in IDLE (ignored when CONTINUOUS=1)
- signal, input, CHANNELS*DATA_BYTES*8, sample bus; channel k = signal[(k+1)*DATA_BYTES*8-1 : k*DATA_BYTES*8]
- to_uart_data, output, 8, byte to UART
- to_uart_valid, output, 1, byte valid
- to_uart_ready, input, 1, UART accepts byte
- to_uart_error, output, 1, always 0 (kept for UART interface compatibility)
- busy, output, 1, high from SOM presentation until EOM accepted
- frame_done, output, 1, one-cycle pulse on the cycle after EOM is accepted
- overrun, output, 1, sticky; set when start=1 while busy=1; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state IDLE; to_uart_data=0, to_uart_valid=0, to_uart_error=0, busy=0, frame_done=0, overrun=0, checksum=0, counters=0. Release is synchronous to clk. Reset mid-frame abandons the frame; no EOM is sent.
- Transfer rule: a byte is transferred on a clk edge where to_uart_valid=1 and to_uart_ready=1. While valid=1 and ready=0, to_uart_data holds stable. valid never drops without a transfer.
- States:
  - IDLE: valid=0. If start=1, or CONTINUOUS=1, then at this edge: snapshot signal into an internal register, clear checksum, go to SOM.
  - SOM: data=SOM_BYTE, valid=1. On transfer, go to PAYLOAD with byte index 0.
  - PAYLOAD: bytes come from the snapshot. Channel 0 first, then ascending channel; within a channel, MSB byte first. On each transfer, checksum += byte (mod 256) and the index increments. After the transfer of byte CHANNELS*DATA_BYTES-1, go to CSUM if CHECKSUM_EN, else EOM.
  - CSUM: data=checksum, valid=1. On transfer, go to EOM.
  - EOM: data=EOM_BYTE, valid=1. On transfer: frame_done=1 for the next cycle, busy=0.
    - CONTINUOUS=0: go to IDLE.
    - CONTINUOUS=1: snapshot in the same edge and go directly to SOM (valid stays 1, no bubble cycle; busy drops for exactly one cycle).
- Checksum covers payload bytes only; SOM and EOM are excluded.
- Throughput: with ready held at 1, one byte per clk. Frame length = 2 + CHANNELS*DATA_BYTES + CHECKSUM_EN bytes.
- Latency: start high in IDLE at edge N gives valid=1 with data=SOM_BYTE after edge N.
- signal changes after the snapshot do not affect the frame in flight.
- busy: 1 in SOM/PAYLOAD/CSUM/EOM, 0 in IDLE.
- start while busy is dropped and sets overrun. start on the same edge that leaves EOM (CONTINUOUS=0) is also dropped and sets overrun.
- Index counter width: clog2(CHANNELS*DATA_BYTES)+1. No wrap beyond the last payload byte.

Test Plan:
- DATA_BYTES=2, CHANNELS=2, CHECKSUM_EN=1, signal=32'hBEEF_1234, ready=1, one start pulse -> bytes 73,12,34,BE,EF,F3,65 on 7 consecutive cycles; frame_done pulses once; busy high for exactly 7 cycles.
- Same config, ready toggled 1-0-0-1 randomly -> identical byte sequence; to_uart_data stable whenever valid=1 and ready=0; no byte duplicated or lost.
- Change signal to 32'h0 one cycle after start -> frame still carries 12,34,BE,EF,F3.
- CHECKSUM_EN=0, DATA_BYTES=4, CHANNELS=1, signal=32'hFFFF_FFFF -> 73,FF,FF,FF,FF,65; payload sum wrap is not emitted.
- CONTINUOUS=1, ready=1 -> back-to-back frames with SOM immediately after EOM, valid never low, frame_done once per frame.
- Start pulsed during the PAYLOAD state -> overrun=1 and stays 1, current frame unaffected. Assert rst_n=0 mid-PAYLOAD -> all outputs 0 immediately; after release, valid stays 0 until the next start.
